// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and data-memory bus shared by dmem_arbiter and its neighbours
//
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requests from port 0 (LSU) and port 1 (debug/DMA)
//   ack0/ack1, rdata0/rdata1, err0/err1             : per-port completion, read data, rejection flag
//   mem_addr, mem_wdata, mem_we, mem_re             : to the data memory
//   mem_rdata                                       : from the data memory (combinational read)
//   busy                                            : arbiter has a transaction in flight
// Modports: slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              err0, err1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, err0, err1,
    output mem_addr, mem_wdata, mem_we, mem_re, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
    input  mem_addr, mem_wdata, mem_we, mem_re, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer in front of the shared data memory
//
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave (requests, acks/rdata/err, memory bus, busy)
// Optional feature: define DMEM_ARB_RANGE_CHK_EN to reject misaligned or
// out-of-range addresses (ack + err one cycle early, no memory access).
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q;
  logic              last_gnt_q;
  logic              gnt_id_q;
  logic              we_l_q;
  logic [ADDR_W-1:0] addr_l_q;
  logic [DATA_W-1:0] wdata_l_q;
  logic              ack0_q, ack1_q;
  logic              err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              grant_d;
  logic              win_we_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic [DATA_W-1:0] win_wdata_d;
  logic              addr_bad_d;
  logic [DATA_W-1:0] rdata_l_d;

  // Tie goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    grant_d = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_d = ~last_gnt_q;
    end else if (!bus.req0) begin
      grant_d = 1'b1;
    end
    win_we_d    = grant_d ? bus.we1    : bus.we0;
    win_addr_d  = grant_d ? bus.addr1  : bus.addr0;
    win_wdata_d = grant_d ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_RANGE_CHK_EN
    addr_bad_d = (win_addr_d[1:0] != 2'b00) ||
                 ({2'b00, win_addr_d[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
`else
    addr_bad_d = 1'b0;
`endif
    rdata_l_d = we_l_q ? '0 : bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_id_q   <= 1'b0;
      we_l_q     <= 1'b0;
      addr_l_q   <= '0;
      wdata_l_q  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      // Completion outputs are single-cycle pulses; only the DONE entry sets them.
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt_id_q   <= grant_d;
            last_gnt_q <= grant_d;
            we_l_q     <= win_we_d;
            addr_l_q   <= win_addr_d;
            wdata_l_q  <= win_wdata_d;
            if (addr_bad_d) begin
              // Rejected grant bypasses ACCESS so the memory never sees it.
              state_q <= DONE;
              if (grant_d) begin
                ack1_q <= 1'b1;
                err1_q <= 1'b1;
              end else begin
                ack0_q <= 1'b1;
                err0_q <= 1'b1;
              end
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          state_q <= DONE;
          if (gnt_id_q) begin
            ack1_q   <= 1'b1;
            rdata1_q <= rdata_l_d;
          end else begin
            ack0_q   <= 1'b1;
            rdata0_q <= rdata_l_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.mem_addr  = addr_l_q;
  assign bus.mem_wdata = wdata_l_q;
  assign bus.mem_re    = (state_q == ACCESS) && !we_l_q;
  // Gating with rst keeps a write abandoned by reset from committing on that edge.
  assign bus.mem_we    = (state_q == ACCESS) && we_l_q && !rst;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: 64 words, combinational read, write on posedge, addr[1:0] ignored.
  logic [31:0] mem [64];
  logic        preload = 1'b1;
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end

  int acc_cnt = 0;
  always @(negedge clk) if (bus.mem_we || bus.mem_re) acc_cnt++;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Waits up to max_cyc falling edges for an ack; port = -1 when none arrives.
  task automatic wait_ack(input int max_cyc, output int port, output int cyc);
    port = -1;
    cyc  = 0;
    while (cyc < max_cyc && port < 0) begin
      @(negedge clk);
      cyc++;
      if (bus.ack0) port = 0;
      else if (bus.ack1) port = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int p, c;
    exp_t e;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.addr0 = 32'h04; bus.addr1 = 32'h08;
    bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.ack0, bus.ack1, bus.mem_we, bus.mem_re, bus.busy} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl got %b want 00000", {bus.ack0, bus.ack1, bus.mem_we, bus.mem_re, bus.busy});
      end
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1, bus.err0, bus.err1} !== 130'b0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h rd0=%h rd1=%h err=%b%b want all 0",
               bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1, bus.err0, bus.err1);
    end
    preload = 1'b0;
    rst = 1'b0;
    sb.push_back('{port: 0, rdata: 32'd1, err: 1'b0});
    wait_ack(5, p, c);
    e = sb.pop_front();
    checks++;
    if (p !== e.port || c !== 2) begin
      errors++;
      $display("FAIL reset_first_grant got port=%0d cyc=%0d want port=%0d cyc=2", p, c, e.port);
    end
    checks++;
    if (bus.rdata0 !== e.rdata) begin
      errors++;
      $display("FAIL reset_first_rdata got %h want %h", bus.rdata0, e.rdata);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int p, c;
    exp_t e;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEADBEEF;
    sb.push_back('{port: 0, rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 32'h10 ||
        bus.mem_wdata !== 32'hDEADBEEF || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_access got we=%b re=%b addr=%h wdata=%h busy=%b want 1 0 10 deadbeef 1",
               bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.busy);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.rdata0 !== e.rdata || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack got ack0=%b ack1=%b rdata0=%h mem_we=%b want 1 0 %h 0",
               bus.ack0, bus.ack1, bus.rdata0, bus.mem_we, e.rdata);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_commit got %h want deadbeef", mem[4]);
    end
    bus.req0 = 1'b1; bus.we0 = 1'b0;
    sb.push_back('{port: 0, rdata: 32'hDEADBEEF, err: 1'b0});
    wait_ack(5, p, c);
    e = sb.pop_front();
    checks++;
    if (p !== e.port || c !== 2 || bus.rdata0 !== e.rdata || bus.rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL rd_back got port=%0d cyc=%0d rdata0=%h rdata1=%h want port=0 cyc=2 rdata0=%h rdata1=0",
               p, c, bus.rdata0, bus.rdata1, e.rdata);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int p, c;
    exp_t e;
    logic [31:0] got;
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.addr0 = 32'h04; bus.addr1 = 32'h08;
    for (int k = 0; k < 4; k++)
      sb.push_back('{port: k % 2, rdata: (k % 2 == 0) ? 32'd1 : 32'd2, err: 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_ack(6, p, c);
      e = sb.pop_front();
      got = (p == 1) ? bus.rdata1 : bus.rdata0;
      checks++;
      if (p !== e.port || c !== ((k == 0) ? 2 : 3) || got !== e.rdata) begin
        errors++;
        $display("FAIL contention_%0d got port=%0d cyc=%0d rdata=%h want port=%0d cyc=%0d rdata=%h",
                 k, p, c, got, e.port, (k == 0) ? 2 : 3, e.rdata);
      end
      if (k == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int p, c;
    exp_t e;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h20; bus.wdata1 = 32'h55;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_access got mem_we=%b busy=%b want 1 1", bus.mem_we, bus.busy);
    end
    rst = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.ack1 !== 1'b0) begin
      errors++;
      $display("FAIL midop_abort got busy=%b ack1=%b want 0 0", bus.busy, bus.ack1);
    end
    wait_ack(5, p, c);
    checks++;
    if (p !== -1) begin
      errors++;
      $display("FAIL midop_no_ack got port=%0d want none", p);
    end
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    sb.push_back('{port: 1, rdata: 32'd8, err: 1'b0});
    wait_ack(5, p, c);
    e = sb.pop_front();
    checks++;
    if (p !== e.port || c !== 2 || bus.rdata1 !== e.rdata) begin
      errors++;
      $display("FAIL midop_readback got port=%0d cyc=%0d rdata1=%h want port=1 cyc=2 rdata1=%h",
               p, c, bus.rdata1, e.rdata);
    end
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int p, c, a0;
    exp_t e;
    a0 = acc_cnt;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h08;
    sb.push_back('{port: 1, rdata: 32'd2, err: 1'b0});
    sb.push_back('{port: 1, rdata: 32'd2, err: 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_ack(6, p, c);
      e = sb.pop_front();
      checks++;
      if (p !== e.port || c !== ((k == 0) ? 2 : 3) || bus.rdata1 !== e.rdata) begin
        errors++;
        $display("FAIL holdover_%0d got port=%0d cyc=%0d rdata1=%h want port=1 cyc=%0d rdata1=%h",
                 k, p, c, bus.rdata1, (k == 0) ? 2 : 3, e.rdata);
      end
    end
    bus.req1 = 1'b0;
    wait_ack(4, p, c);
    checks++;
    if (p !== -1 || acc_cnt - a0 !== 2) begin
      errors++;
      $display("FAIL holdover_count got extra_ack=%0d accesses=%0d want -1 2", p, acc_cnt - a0);
    end
    a0 = acc_cnt;
    bus.req1 = 1'b1;
    sb.push_back('{port: 1, rdata: 32'd2, err: 1'b0});
    wait_ack(5, p, c);
    e = sb.pop_front();
    checks++;
    if (p !== e.port || bus.rdata1 !== e.rdata) begin
      errors++;
      $display("FAIL single_ack got port=%0d rdata1=%h want port=1 rdata1=%h", p, bus.rdata1, e.rdata);
    end
    bus.req1 = 1'b0;
    wait_ack(4, p, c);
    checks++;
    if (p !== -1 || acc_cnt - a0 !== 1) begin
      errors++;
      $display("FAIL single_count got extra_ack=%0d accesses=%0d want -1 1", p, acc_cnt - a0);
    end
  endtask

  task automatic test_range();
    int p, c, a0;
    exp_t e;
    bus.we0 = 1'b0;
`ifdef DMEM_ARB_RANGE_CHK_EN
    a0 = acc_cnt;
    for (int k = 0; k < 2; k++) begin
      bus.req0 = 1'b1;
      bus.addr0 = (k == 0) ? 32'h100 : 32'h102;
      sb.push_back('{port: 0, rdata: 32'h0, err: 1'b1});
      wait_ack(5, p, c);
      e = sb.pop_front();
      checks++;
      if (p !== e.port || c !== 1 || bus.err0 !== e.err || bus.rdata0 !== e.rdata) begin
        errors++;
        $display("FAIL range_reject_%0d got port=%0d cyc=%0d err0=%b rdata0=%h want port=0 cyc=1 err0=1 rdata0=0",
                 k, p, c, bus.err0, bus.rdata0);
      end
      bus.req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    checks++;
    if (acc_cnt - a0 !== 0) begin
      errors++;
      $display("FAIL range_no_access got %0d want 0", acc_cnt - a0);
    end
`else
    a0 = 0;
    bus.req0 = 1'b1; bus.addr0 = 32'h100;
    sb.push_back('{port: 0, rdata: mem[0], err: 1'b0});
    wait_ack(5, p, c);
    e = sb.pop_front();
    checks++;
    if (p !== e.port || c !== 2 || bus.err0 !== e.err || bus.rdata0 !== e.rdata) begin
      errors++;
      $display("FAIL range_nochk got port=%0d cyc=%0d err0=%b rdata0=%h want port=0 cyc=2 err0=0 rdata0=%h",
               p, c, bus.err0, bus.rdata0, e.rdata);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (a0 !== 0 || bus.err1 !== 1'b0) begin
      errors++;
      $display("FAIL range_err1 got %b want 0", bus.err1);
    end
`endif
    bus.req0 = 1'b1; bus.addr0 = 32'hFC;
    sb.push_back('{port: 0, rdata: 32'd63, err: 1'b0});
    wait_ack(5, p, c);
    e = sb.pop_front();
    checks++;
    if (p !== e.port || c !== 2 || bus.err0 !== e.err || bus.rdata0 !== e.rdata) begin
      errors++;
      $display("FAIL range_last_word got port=%0d cyc=%0d err0=%b rdata0=%h want port=0 cyc=2 err0=0 rdata0=%h",
               p, c, bus.err0, bus.rdata0, e.rdata);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_reset_mid_op();
    test_back_to_back();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
